// File: rtl/alu_frame_sequencer.sv
// -----------------------------------------------------------------------------
// alu_frame_sequencer
//
// Framed-command controller between the UART RX/TX FIFOs and the shared ALU.
// Hunts for SYNC_BYTE, then collects opcode, operand A, operand B and a checksum
// byte (OP ^ A ^ B). A good frame is committed to the ALU outputs, the result is
// latched and sent back followed by a status byte. Checksum errors and
// inter-byte timeouts answer with RESULT=00 and a non-zero status, leave the ALU
// outputs untouched and bump a saturating error counter.
//
// Ports
//   i_clk, i_reset           clock, asynchronous active-low reset
//   i_rx_empty, i_rx_data    RX FIFO status and show-ahead head byte
//   o_rx_read                RX FIFO pop (one byte per cycle at most)
//   i_tx_full                TX FIFO full
//   o_tx_write, o_tx_data    TX FIFO push and byte
//   o_alu_opcode/op_a/op_b   committed ALU operands (change only in EXEC)
//   i_alu_result             combinational ALU result
//   o_busy                   high whenever the sequencer is not idle
//   o_err_count              saturating count of bad frames
// -----------------------------------------------------------------------------
module alu_frame_sequencer #(
    parameter int          NB_DATA        = 8,
    parameter int          NB_OPCODE      = 6,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          NB_TIMEOUT     = 20,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx_empty,
    input  logic [NB_DATA-1:0]   i_rx_data,
    output logic                 o_rx_read,
    input  logic                 i_tx_full,
    output logic                 o_tx_write,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic [NB_OPCODE-1:0] o_alu_opcode,
    output logic [NB_DATA-1:0]   o_alu_op_a,
    output logic [NB_DATA-1:0]   o_alu_op_b,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic                 o_busy,
    output logic [7:0]           o_err_count
);

    typedef enum logic [3:0] {
        IDLE, GET_OP, GET_A, GET_B, GET_CHK, EXEC, LATCH, SEND_RES, SEND_STAT
    } state_t;

    localparam logic [NB_DATA-1:0]    STAT_OK      = NB_DATA'(8'h00);
    localparam logic [NB_DATA-1:0]    STAT_CHK_ERR = NB_DATA'(8'h01);
    localparam logic [NB_DATA-1:0]    STAT_TIMEOUT = NB_DATA'(8'h02);
    localparam logic [NB_TIMEOUT-1:0] TIMER_LAST   = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [NB_DATA-1:0]   op_byte_q;   // full opcode byte, needed for the checksum
    logic [NB_DATA-1:0]   a_q, b_q;
    logic [NB_DATA-1:0]   result_q, status_q;
    logic [NB_TIMEOUT-1:0] timer_q;

    logic in_rx_state, in_get, pop, timed_out, chk_ok;

    assign in_rx_state = (state_q == IDLE) || in_get;
    assign in_get      = (state_q == GET_OP) || (state_q == GET_A) ||
                         (state_q == GET_B)  || (state_q == GET_CHK);
    // Gated by reset so the pop strobe is low for the whole reset interval.
    assign pop         = i_reset && in_rx_state && !i_rx_empty;
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign timed_out   = in_get && !pop && (timer_q == TIMER_LAST);
    assign chk_ok      = (i_rx_data == (op_byte_q ^ a_q ^ b_q));

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d    = state_q;
        o_tx_write = 1'b0;
        o_tx_data  = '0;
        unique case (state_q)
            IDLE:    if (pop && i_rx_data == NB_DATA'(SYNC_BYTE)) state_d = GET_OP;
            GET_OP:  if (pop) state_d = GET_A;   else if (timed_out) state_d = SEND_RES;
            GET_A:   if (pop) state_d = GET_B;   else if (timed_out) state_d = SEND_RES;
            GET_B:   if (pop) state_d = GET_CHK; else if (timed_out) state_d = SEND_RES;
            GET_CHK: if (pop) state_d = chk_ok ? EXEC : SEND_RES;
                     else if (timed_out) state_d = SEND_RES;
            EXEC:    state_d = LATCH;
            LATCH:   state_d = SEND_RES;
            SEND_RES: begin
                o_tx_data = result_q;
                if (!i_tx_full) begin
                    o_tx_write = 1'b1;
                    state_d    = SEND_STAT;
                end
            end
            SEND_STAT: begin
                o_tx_data = status_q;
                if (!i_tx_full) begin
                    o_tx_write = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_rx_read = pop;
    assign o_busy    = (state_q != IDLE);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            op_byte_q    <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            status_q     <= '0;
            timer_q      <= '0;
            o_alu_opcode <= '0;
            o_alu_op_a   <= '0;
            o_alu_op_b   <= '0;
            o_err_count  <= '0;
        end else begin
            // Timer only runs while waiting for a frame byte.
            if (pop || !in_get) timer_q <= '0;
            else                timer_q <= timer_q + 1'b1;

            if (pop && state_q == GET_OP) op_byte_q <= i_rx_data;
            if (pop && state_q == GET_A)  a_q       <= i_rx_data;
            if (pop && state_q == GET_B)  b_q       <= i_rx_data;

            if (state_q == EXEC) begin
                o_alu_opcode <= op_byte_q[NB_OPCODE-1:0];
                o_alu_op_a   <= a_q;
                o_alu_op_b   <= b_q;
            end

            if (state_q == LATCH) begin
                result_q <= i_alu_result;
                status_q <= STAT_OK;
            end

            if (pop && state_q == GET_CHK && !chk_ok) begin
                result_q <= '0;
                status_q <= STAT_CHK_ERR;
            end else if (timed_out) begin
                result_q <= '0;
                status_q <= STAT_TIMEOUT;
            end

            if (((pop && state_q == GET_CHK && !chk_ok) || timed_out) &&
                (o_err_count != 8'hFF))
                o_err_count <= o_err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_frame_sequencer
//
// Directed-vector bench: a queue-backed RX FIFO feeds frames, a queue collects
// TX pushes, and a small ALU model answers the committed operands.
// -----------------------------------------------------------------------------
module tb_alu_frame_sequencer;

    localparam int TO_CYCLES = 20;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_rx_empty = 1'b1;
    logic [7:0] i_rx_data = 8'h00;
    logic       o_rx_read;
    logic       i_tx_full = 1'b0;
    logic       o_tx_write;
    logic [7:0] o_tx_data;
    logic [5:0] o_alu_opcode;
    logic [7:0] o_alu_op_a, o_alu_op_b;
    logic [7:0] i_alu_result;
    logic       o_busy;
    logic [7:0] o_err_count;

    alu_frame_sequencer #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_rx_empty   (i_rx_empty),
        .i_rx_data    (i_rx_data),
        .o_rx_read    (o_rx_read),
        .i_tx_full    (i_tx_full),
        .o_tx_write   (o_tx_write),
        .o_tx_data    (o_tx_data),
        .o_alu_opcode (o_alu_opcode),
        .o_alu_op_a   (o_alu_op_a),
        .o_alu_op_b   (o_alu_op_b),
        .i_alu_result (i_alu_result),
        .o_busy       (o_busy),
        .o_err_count  (o_err_count)
    );

    always #5 i_clk = ~i_clk;

    // Small ALU model: ADD, SUB, AND, OR, XOR.
    always_comb begin
        case (o_alu_opcode)
            6'h20:   i_alu_result = o_alu_op_a + o_alu_op_b;
            6'h22:   i_alu_result = o_alu_op_a - o_alu_op_b;
            6'h24:   i_alu_result = o_alu_op_a & o_alu_op_b;
            6'h25:   i_alu_result = o_alu_op_a | o_alu_op_b;
            6'h26:   i_alu_result = o_alu_op_a ^ o_alu_op_b;
            default: i_alu_result = 8'h00;
        endcase
    end

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int n_vectors = 0;
    int n_miscompares = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    int first_tx_cyc = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // FIFO models: outputs sampled at negedge, RX head refreshed 1 ns after posedge.
    initial begin
        logic rd;
        forever begin
            @(negedge i_clk);
            cyc++;
            rd = o_rx_read;
            if (rd) last_pop_cyc = cyc;
            if (o_tx_write) begin
                if (tx_q.size() == 0) first_tx_cyc = cyc;
                tx_q.push_back(o_tx_data);
            end
            @(posedge i_clk);
            #1;
            if (rd && rx_q.size() > 0) void'(rx_q.pop_front());
            i_rx_empty = (rx_q.size() == 0);
            i_rx_data  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    task automatic push_frame(input logic [7:0] op, a, b, chk);
        rx_q.push_back(8'hA5);
        rx_q.push_back(op);
        rx_q.push_back(a);
        rx_q.push_back(b);
        rx_q.push_back(chk);
    endtask

    task automatic expect_response(input string tag, input logic [7:0] res,
                                   input logic [7:0] stat, input int budget);
        int k;
        k = 0;
        while (tx_q.size() < 2 && k < budget) begin tick(1); k++; end
        check({tag, "_tx_count"}, tx_q.size(), 2);
        if (tx_q.size() >= 2) begin
            check({tag, "_result"}, tx_q[0], res);
            check({tag, "_status"}, tx_q[1], stat);
        end
        tx_q.delete();
        k = 0;
        while (o_busy && k < 20) begin tick(1); k++; end
        check({tag, "_idle"}, o_busy, 1'b0);
    endtask

    initial begin
        // Reset state
        #3;
        check("reset_ctrl", {o_rx_read, o_tx_write, o_busy, o_tx_data}, 11'h000);
        check("reset_alu", {o_alu_opcode, o_alu_op_a, o_alu_op_b}, 22'h0);
        check("reset_err", o_err_count, 8'h00);
        tick(2);
        i_reset = 1'b1;
        tick(2);

        // 1: good ADD frame, with latency from CHK pop to first push
        push_frame(8'h20, 8'h05, 8'h03, 8'h26);
        expect_response("t1", 8'h08, 8'h00, 100);
        check("t1_latency", first_tx_cyc - last_pop_cyc, 3);
        check("t1_alu", {o_alu_opcode, o_alu_op_a, o_alu_op_b}, {6'h20, 8'h05, 8'h03});
        check("t1_err", o_err_count, 8'h00);

        // 2: bad checksum; ALU outputs untouched
        push_frame(8'h20, 8'h05, 8'h03, 8'h27);
        expect_response("t2", 8'h00, 8'h01, 100);
        check("t2_alu", {o_alu_opcode, o_alu_op_a, o_alu_op_b}, {6'h20, 8'h05, 8'h03});
        check("t2_err", o_err_count, 8'h01);

        // 3: junk before sync, SUB 0F-01
        rx_q.push_back(8'h11);
        push_frame(8'h22, 8'h0F, 8'h01, 8'h2C);
        expect_response("t3", 8'h0E, 8'h00, 100);
        check("t3_alu", {o_alu_opcode, o_alu_op_a, o_alu_op_b}, {6'h22, 8'h0F, 8'h01});

        // Inter-byte gap shorter than the timeout is tolerated
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'h20);
        tick(17);
        check("gap_no_tx", tx_q.size(), 0);
        rx_q.push_back(8'h05);
        rx_q.push_back(8'h03);
        rx_q.push_back(8'h26);
        expect_response("gap", 8'h08, 8'h00, 100);
        check("gap_err", o_err_count, 8'h01);

        // 4: timeout after OP byte
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'h20);
        tick(12);
        check("t4_early", {o_busy, 8'(tx_q.size())}, {1'b1, 8'd0});
        expect_response("t4", 8'h00, 8'h02, 60);
        check("t4_err", o_err_count, 8'h02);
        check("t4_alu", {o_alu_opcode, o_alu_op_a, o_alu_op_b}, {6'h20, 8'h05, 8'h03});

        // 5: TX back-pressure, AND 3C&0F
        i_tx_full = 1'b1;
        push_frame(8'h24, 8'h3C, 8'h0F, 8'h17);
        tick(50);
        check("t5_held", {o_busy, 8'(tx_q.size())}, {1'b1, 8'd0});
        i_tx_full = 1'b0;
        expect_response("t5", 8'h0C, 8'h00, 20);
        check("t5_err", o_err_count, 8'h02);

        // 6a: reset mid GET_B
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'h25);
        rx_q.push_back(8'h01);
        tick(8);
        check("t6a_busy", o_busy, 1'b1);
        i_reset = 1'b0;
        rx_q.push_back(8'h77);
        tick(2);
        check("t6a_ctrl", {o_rx_read, o_tx_write, o_busy, o_tx_data}, 11'h000);
        check("t6a_alu", {o_alu_opcode, o_alu_op_a, o_alu_op_b, o_err_count}, 30'h0);
        rx_q.delete();
        tick(1);
        i_reset = 1'b1;
        tick(1);

        // 6b: reset mid SEND_STAT (result pushed, status held by full)
        push_frame(8'h20, 8'h05, 8'h03, 8'h26);
        begin
            int k;
            k = 0;
            while (!o_tx_write && k < 50) begin @(negedge i_clk); k++; end
            check("t6b_reach_send", o_tx_write, 1'b1);
        end
        @(posedge i_clk);
        #2;
        i_tx_full = 1'b1;
        tick(3);
        check("t6b_stat_held", {o_busy, o_tx_write, o_tx_data}, {2'b10, 8'h00});
        i_reset = 1'b0;
        #1;
        check("t6b_ctrl", {o_rx_read, o_tx_write, o_busy, o_tx_data}, 11'h000);
        check("t6b_alu", {o_alu_opcode, o_alu_op_a, o_alu_op_b, o_err_count}, 30'h0);
        i_tx_full = 1'b0;
        tick(2);
        tx_q.delete();
        i_reset = 1'b1;
        tick(3);
        check("t6b_no_partial", tx_q.size(), 0);

        // Frame after reset: OR F0|0F
        push_frame(8'h25, 8'hF0, 8'h0F, 8'hDA);
        expect_response("t6c", 8'hFF, 8'h00, 100);
        check("t6c_alu", {o_alu_opcode, o_alu_op_a, o_alu_op_b}, {6'h25, 8'hF0, 8'h0F});
        check("t6c_err", o_err_count, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
